// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, with a small byte FIFO ahead of the framing FSM.
// Every output is registered from next-state values, so the line never glitches.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_clock,
  input  logic       i_rst_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          full_d;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          bit_end;

  logic          tx_serial_d;
  logic          tx_active_d;
  logic          tx_done_d;
  logic          tx_ready_d;

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  assign push       = i_tx_dv && o_tx_ready;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  assign wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;

  // Ready is registered from the post-update occupancy, so it tracks the FIFO exactly.
  assign full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  assign tx_ready_d = !full_d;

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_tx_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  assign bit_end = (clk_cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_d   = StStart;
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end
      end

      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          clk_cnt_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase

    if (pop) begin
      shreg_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    tx_serial_d = 1'b1;
    tx_active_d = 1'b0;
    case (state_d)
      StStart: begin
        tx_serial_d = 1'b0;
        tx_active_d = 1'b1;
      end
      StData: begin
        tx_serial_d = shreg_d[bit_idx_d];
        tx_active_d = 1'b1;
      end
      StStop: begin
        tx_serial_d = 1'b1;
        tx_active_d = 1'b1;
      end
      default: begin
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
      end
    endcase
    tx_done_d = (state_d == StStop) && (clk_cnt_d == CntLast);
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      o_tx_ready  <= 1'b1;
      o_tx_serial <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      o_tx_ready  <= tx_ready_d;
      o_tx_serial <= tx_serial_d;
      o_tx_active <= tx_active_d;
      o_tx_done   <= tx_done_d;
    end
  end

endmodule
